sram_rd_stream: RTL and testbench

- Downstream consumer of a 1-read-port synchronous SRAM bank (1-cycle read latency).
- Converts a valid/ready read-request stream into SRAM read strobes.
- Captures the SRAM read data into a credit-managed response buffer, so the consumer can apply backpressure without losing data.
- One instance per SRAM read port.

---
 rtl/sram_rd_stream.sv | 112 +++++++++++
 tb/tb_sram_rd_stream.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rd_stream.sv
// Read-request stream to 1-cycle-latency SRAM port, with a credit-managed response buffer.
// Optional write-first bypass for same-cycle read/write collisions: define SRAM_RD_STREAM_BYPASS_EN.
module sram_rd_stream #(
  parameter  int W         = 32,
  parameter  int N         = 8,
  parameter  int BUF_DEPTH = 4,
  localparam int ADDR_W    = $clog2(N),
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_rdy,
  output logic              rsp_vld,
  output logic [W-1:0]      rsp_data,
  input  logic              rsp_rdy,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [W-1:0]      sram_rdata,
  input  logic              sram_wen,
  input  logic [ADDR_W-1:0] sram_waddr,
  input  logic [W-1:0]      sram_wdata,
  output logic [OCC_W-1:0]  occupancy
);

  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [W-1:0]     buf_q [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] used;
  logic             inflight;
  logic             live;
  logic             issue;
  logic             capture;
  logic             pop;
  logic [W-1:0]     cap_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A read in flight already owns a buffer slot, so it counts against the credits.
  assign used      = occ + OCC_W'(inflight);
  assign req_rdy   = live && (used < OCC_W'(BUF_DEPTH));
  assign issue     = req_vld && req_rdy;
  assign sram_ren  = issue;
  assign sram_raddr = req_addr;
  assign capture   = inflight;
  assign rsp_vld   = (occ != '0);
  assign pop       = rsp_vld && rsp_rdy;
  assign rsp_data  = buf_q[rd_ptr];
  assign occupancy = used;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live     <= 1'b0;
      inflight <= 1'b0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      live     <= 1'b1;
      inflight <= issue;
      occ      <= occ + OCC_W'(capture) - OCC_W'(pop);
      if (capture) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // NOTE: the storage is reset (it is only a few entries) so rsp_data reads 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else if (capture) begin
      buf_q[wr_ptr] <= cap_data;
    end
  end

`ifdef SRAM_RD_STREAM_BYPASS_EN
  logic         byp_q;
  logic [W-1:0] byp_data_q;

  // Snapshot the colliding write at issue; it overrides the SRAM output at capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else if (issue) begin
      byp_q      <= sram_wen && (sram_waddr == req_addr);
      byp_data_q <= sram_wdata;
    end
  end

  assign cap_data = byp_q ? byp_data_q : sram_rdata;
`else
  logic unused_snoop;
  assign unused_snoop = ^{sram_wen, sram_waddr, sram_wdata};
  assign cap_data     = sram_rdata;
`endif

`ifndef SYNTHESIS
  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W + 1)'(N);

  addr_in_range: assert property (@(posedge clk) disable iff (rst)
    issue |-> ({1'b0, req_addr} < ADDR_LIM));
`endif

endmodule

// File: tb/tb_sram_rd_stream.sv
// Scoreboard bench for sram_rd_stream: driver pushes expected data on accept, monitor pops on each response.
module tb_sram_rd_stream;

  logic        clk;
  logic        rst;
  logic        req_vld;
  logic [2:0]  req_addr;
  logic        req_rdy;
  logic        rsp_vld;
  logic [31:0] rsp_data;
  logic        rsp_rdy;
  logic        sram_ren;
  logic [2:0]  sram_raddr;
  logic [31:0] sram_rdata;
  logic        sram_wen;
  logic [2:0]  sram_waddr;
  logic [31:0] sram_wdata;
  logic [2:0]  occupancy;

  typedef struct {
    logic [31:0] data;
    bit          chk;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cycles[$];
  int   checks = 0;
  int   errors = 0;
  int   stalls = 0;
  int   cyc = 0;
  logic [31:0] mem [8];

  sram_rd_stream #(.W(32), .N(8), .BUF_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_addr(req_addr), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_rdy(rsp_rdy),
    .sram_ren(sram_ren), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
    .sram_wen(sram_wen), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: 1-cycle read latency, read-first on collision.
  always @(posedge clk) begin
    if (sram_wen) mem[sram_waddr] <= sram_wdata;
    if (sram_ren) sram_rdata <= mem[sram_raddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every consumed response is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && rsp_vld && rsp_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got 0x%0h, expected no response (t=%0t)", rsp_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk) check("rsp_data", rsp_data, e.data);
      end
      pop_cycles.push_back(cyc);
    end
  end

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic sram_write(input logic [2:0] a, input logic [31:0] d);
    sram_wen = 1'b1;
    sram_waddr = a;
    sram_wdata = d;
    @(posedge clk); #1;
    sram_wen = 1'b0;
  endtask

  task automatic send(input logic [2:0] a, input logic [31:0] d, input bit chk);
    int tries = 0;
    bit done = 1'b0;
    req_vld = 1'b1;
    req_addr = a;
    while (!done) begin
      @(negedge clk);
      if (req_rdy) begin
        check("sram_ren", sram_ren, 1);
        check("sram_raddr", sram_raddr, a);
        exp_q.push_back('{data: d, chk: chk});
        done = 1'b1;
      end else begin
        stalls++;
        tries++;
        if (tries > 50) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: addr %0d never accepted, expected accept (t=%0t)", a, $time);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    req_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx0;
    rst = 1'b1;
    req_vld = 1'b0;
    req_addr = '0;
    rsp_rdy = 1'b0;
    sram_wen = 1'b0;
    sram_waddr = '0;
    sram_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_rdy", req_rdy, 0);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_sram_ren", sram_ren, 0);
    check("rst_occupancy", occupancy, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_req_rdy", req_rdy, 1);

    // Single read, held for a cycle before popping
    sram_write(3'd3, 32'hDEAD_BEEF);
    send(3'd3, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    check("single_t1_rsp_vld", rsp_vld, 0);
    check("single_t1_occ", occupancy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_t2_rsp_vld", rsp_vld, 1);
    check("single_t2_rsp_data", rsp_data, 32'hDEAD_BEEF);
    check("single_t2_occ", occupancy, 1);
    @(posedge clk); #1;
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
    @(negedge clk);
    check("single_after_pop_occ", occupancy, 0);
    check("single_after_pop_vld", rsp_vld, 0);
    @(posedge clk); #1;

    // Streaming at full rate
    for (int i = 0; i < 8; i++) sram_write(3'(i), 32'h100 + 32'(i));
    rsp_rdy = 1'b1;
    stalls = 0;
    idx0 = pop_cycles.size();
    for (int i = 0; i < 8; i++) send(3'(i), 32'h100 + 32'(i), 1'b1);
    drain();
    check("stream_stalls", stalls, 0);
    check("stream_pop_count", pop_cycles.size() - idx0, 8);
    if (pop_cycles.size() - idx0 == 8)
      check("stream_pop_span", pop_cycles[idx0 + 7] - pop_cycles[idx0], 7);

    // Backpressure: four credits, then stall
    rsp_rdy = 1'b0;
    stalls = 0;
    for (int i = 0; i < 4; i++) send(3'(i), 32'h100 + 32'(i), 1'b1);
    check("bp_first4_stalls", stalls, 0);
    req_vld = 1'b1;
    req_addr = 3'd4;
    @(negedge clk);
    check("bp_full_req_rdy", req_rdy, 0);
    check("bp_full_occ", occupancy, 4);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_full2_req_rdy", req_rdy, 0);
    check("bp_full2_occ", occupancy, 4);
    check("bp_full2_rsp_vld", rsp_vld, 1);
    @(posedge clk); #1;
    rsp_rdy = 1'b1;
    @(negedge clk);
    check("bp_pop_cycle_req_rdy", req_rdy, 0);
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
    stalls = 0;
    send(3'd4, 32'h104, 1'b1);
    check("bp_reaccept_stalls", stalls, 0);
    @(negedge clk);
    check("bp_refull_occ", occupancy, 4);
    check("bp_refull_req_rdy", req_rdy, 0);
    @(posedge clk); #1;

    // Held data under backpressure
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rsp_vld", rsp_vld, 1);
      check("hold_rsp_data", rsp_data, 32'h101);
      @(posedge clk); #1;
    end
    rsp_rdy = 1'b1;
    drain();
    rsp_rdy = 1'b0;

    // Mid-stream asynchronous reset: 3 buffered + 1 in flight
    for (int i = 0; i < 4; i++) send(3'(i), 32'h100 + 32'(i), 1'b1);
    #1;
    check("pre_rst_occ", occupancy, 4);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_rsp_vld", rsp_vld, 0);
    check("midrst_occ", occupancy, 0);
    check("midrst_req_rdy", req_rdy, 0);
    exp_q.delete();
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    rsp_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("postrst_rsp_vld", rsp_vld, 0);
      check("postrst_occ", occupancy, 0);
      @(posedge clk); #1;
    end
    check("postrst_req_rdy", req_rdy, 1);
    send(3'd3, 32'h103, 1'b1);
    drain();

    // Same-cycle read/write collision on address 5
    sram_write(3'd5, 32'h11);
    sram_wen = 1'b1;
    sram_waddr = 3'd5;
    sram_wdata = 32'h22;
`ifdef SRAM_RD_STREAM_BYPASS_EN
    send(3'd5, 32'h22, 1'b1);
`else
    send(3'd5, 32'h22, 1'b0);
`endif
    sram_wen = 1'b0;
    @(negedge clk);
    check("coll_t1_rsp_vld", rsp_vld, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("coll_t2_rsp_vld", rsp_vld, 1);
    @(posedge clk); #1;
    send(3'd5, 32'h22, 1'b1);
    drain();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
